d5m_frame_axis_bridge: RTL and testbench
========================================

Name: d5m_frame_axis_bridge

Overview:
- Parametrised successor to the D5M pixel/frame front end.
- Accepts a raw frame/line-valid pixel bus (idata/ifval/ilval) and emits AXI4-Stream video: tuser marks start of frame, tlast marks end of line.
- Buffers pixels in an internal FIFO to absorb downstream backpressure, with overflow detection and frame resync.
- Measures frame geometry and can substitute a colour-bar test pattern. Sits between the camera capture path and the VDMA/rgb_s_axis input.

Parameters:
DATA_WIDTH, 24, pixel width in bits (stream tdata width)
FIFO_DEPTH, 64, pixel FIFO entries; power of two, at least 4
X_WIDTH, 12, column counter / frame_width width
Y_WIDTH, 12, row counter / frame_height width
BAR_SHIFT, 5, test-pattern bar index = xCord >> BAR_SHIFT, modulo 8

Ports:
ACLK  in  1  single clock for all logic
ARESETN  in  1  synchronous active-low reset, sampled on rising ACLK
idata  in  DATA_WIDTH  pixel data, valid when ifval&ilval
ifval  in  1  frame valid
ilval  in  1  line valid
cfg_test_en  in  1  select colour-bar pattern; sampled at frame start
cfg_clr_ovf  in  1  one-cycle pulse that clears ovf_flag
m_axis_tready  in  1  downstream ready
m_axis_tvalid  out  1  stream valid
m_axis_tdata  out  DATA_WIDTH  pixel
m_axis_tuser  out  1  first pixel of frame
m_axis_tlast  out  1  last pixel of line
xCord  out  X_WIDTH  column of last accepted pixel
yCord  out  Y_WIDTH  row of last accepted pixel
frame_width  out  X_WIDTH  pixels per line, last complete frame
frame_height  out  Y_WIDTH  lines, last complete frame
frame_count  out  16  completed frames, wraps at 65535 to 0
endOfFrame  out  1  one-cycle pulse on ifval falling edge in ACTIVE
ovf_flag  out  1  sticky FIFO overflow

Behaviour:
- Reset: all outputs are 0, FIFO is empty, hold register is invalid, and the FSM enters WAIT_VB. Reset mid-frame discards everything in flight.
- Edges are detected against a one-cycle registered copy of ifval/ilval. Accepted pixel = ifval&ilval while in ACTIVE.
- FSM WAIT_VB: wait for ifval=0, then go to ARMED. This prevents a partial frame after reset or drop.
- FSM ARMED: on ifval rising, go to ACTIVE. Latch cfg_test_en for the whole frame. Set the sof pending flag. Clear x/y.
- FSM ACTIVE: capture pixels. On ifval falling: pulse endOfFrame, latch frame_height=y and frame_width=last line length, increment frame_count, then go to ARMED.
- FSM DROP: entered on overflow. Ignore input until ifval=0, then go to ARMED. No partial frame is ever streamed after the overflow point.
- Counters: x increments per accepted pixel and clears on ilval falling. y increments on each ilval falling within ACTIVE. xCord/yCord show the coordinates of the pixel just accepted.
- EOL lookahead: each accepted pixel is placed in a one-entry hold register with its sof bit. The held pixel is written to the FIFO with eol=0 in the cycle its successor is accepted, or with eol=1 in the cycle ilval falls. ifval falling with ilval still high also flushes with eol=1.
- Single-pixel line: the written entry has sof and eol both set if first in frame.
- Data mux: cfg_test_en latched=1 replaces idata by bar colour k=(x>>BAR_SHIFT)&7. Bars in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero in the 8-bit R,G,B fields of 24-bit data; for other widths, fields are DATA_WIDTH/3 bits.
- FIFO: entries are {sof, eol, data}, first-word-fall-through, registered output.
- Latency: write to m_axis_tvalid=1 is one cycle. Minimum input-to-output is 2 cycles after the successor event.
- Full and write in the same cycle as a read: the write is accepted.
- Full and write without a read: the entry is dropped, ovf_flag is set, the hold register is cleared, and the FSM goes to DROP.
- ovf_flag handling: cfg_clr_ovf clears ovf_flag. A simultaneous set wins over clear.
- AXIS rules: tvalid never drops without a handshake. tdata/tuser/tlast are stable while tvalid&!tready. A beat transfers on tvalid&tready.
- frame_count/frame_width/frame_height are not updated by frames that ended in DROP.

Decomposition:
- Package d5m_axis_pkg holds the FSM enum (WAIT_VB, ARMED, ACTIVE, DROP), the colour-bar constant array, and the FIFO entry struct type.
- Sub-module axis_sync_fifo_fwft, parametrised by WIDTH/DEPTH, provides full/empty/count and is reusable elsewhere.

Test Plan:
1. Frame of 2 lines × 4 pixels (ilval gap 3 cycles), idata 1..8, tready=1 -> 8 beats 1..8. tuser only on beat 1; tlast on beats 4 and 8. frame_width=4, frame_height=2, frame_count=1, one endOfFrame pulse.
2. Same frame with tready toggling 1,0,0,1 -> identical beat sequence. tdata/tuser/tlast are held stable during stalls, no ovf_flag.
3. FIFO_DEPTH=4, tready=0, 1 line × 16 pixels -> ovf_flag=1, FSM in DROP. The next frame streams complete with tuser on its first beat. frame_count counts only the good frame.
4. cfg_test_en=1, BAR_SHIFT=1, 16-pixel line -> tdata pairs FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Toggling cfg_test_en mid-frame has no effect until the next frame.
5. Line of 1 pixel as the first line -> single beat with tuser=1 and tlast=1.
6. ARESETN low mid-line, released while ifval=1 -> no output until ifval falls and rises again. First beat has tuser=1, and all outputs read 0 during reset.

Source files
------------

// File: rtl/d5m_axis_pkg.sv
// Shared types and constants for the D5M frame to AXI4-Stream bridge.
package d5m_axis_pkg;

  typedef enum logic [1:0] {
    WAIT_VB = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2,
    DROP    = 2'd3
  } bridge_state_e;

  // Channel enables {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  // Sideband bits stored ahead of the pixel in every FIFO entry
  typedef struct packed {
    logic sof;
    logic eol;
  } entry_tag_t;

  localparam int TAG_W = $bits(entry_tag_t);

endpackage

// File: rtl/axis_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// Capacity is DEPTH entries in total: DEPTH-1 in the array plus the output register.
module axis_sync_fifo_fwft #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             pop, load, mem_rd, mem_wr, bypass;

  assign full    = out_valid_q && (mem_cnt_q == CW'(DEPTH - 1));
  assign empty   = !out_valid_q;
  assign count   = mem_cnt_q + CW'(out_valid_q);
  assign rd_data = out_data_q;

  always_comb begin
    pop    = out_valid_q & rd_en;
    load   = !out_valid_q | pop;
    mem_rd = load && (mem_cnt_q != '0);
    // An empty array lets a write go straight into the output register
    bypass = load && (mem_cnt_q == '0) && wr_en;
    mem_wr = wr_en && !bypass && (!full || pop);

    wr_ptr_d    = mem_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = mem_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    mem_cnt_d   = mem_cnt_q + CW'(mem_wr) - CW'(mem_rd);
    out_valid_d = load ? (mem_rd | bypass) : out_valid_q;
    out_data_d  = out_data_q;
    if (mem_rd) begin
      out_data_d = mem[rd_ptr_q];
    end else if (bypass) begin
      out_data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: rtl/d5m_frame_axis_bridge.sv
// Converts a frame/line-valid pixel bus into AXI4-Stream video with SOF/EOL
// sideband, FIFO buffering, overflow resync, geometry capture and colour bars.
module d5m_frame_axis_bridge
  import d5m_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 64,
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12,
  parameter int BAR_SHIFT  = 5
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ifval,
  input  logic                  ilval,
  input  logic                  cfg_test_en,
  input  logic                  cfg_clr_ovf,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [X_WIDTH-1:0]    xCord,
  output logic [Y_WIDTH-1:0]    yCord,
  output logic [X_WIDTH-1:0]    frame_width,
  output logic [Y_WIDTH-1:0]    frame_height,
  output logic [15:0]           frame_count,
  output logic                  endOfFrame,
  output logic                  ovf_flag
);

  localparam int FW = DATA_WIDTH / 3;
  localparam int EW = DATA_WIDTH + TAG_W;

  bridge_state_e state_q, state_d;
  logic                  ifval_q, ifval_d, ilval_q, ilval_d;
  logic                  test_en_q, test_en_d;
  logic                  sof_pend_q, sof_pend_d;
  logic [X_WIDTH-1:0]    x_q, x_d, last_len_q, last_len_d, xcord_q, xcord_d, frame_w_q, frame_w_d;
  logic [Y_WIDTH-1:0]    y_q, y_d, ycord_q, ycord_d, frame_h_q, frame_h_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  eof_q, eof_d, ovf_q, ovf_d;
  logic                  hold_valid_q, hold_valid_d, hold_sof_q, hold_sof_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  logic                  pix_ok, fv_rise, fv_fall, in_active, acc, line_end, ovf_evt;
  logic [2:0]            bar_k, bar_rgb;
  logic [DATA_WIDTH-1:0] bar_data, pix_data;
  logic                  fifo_wr, fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_wdata, fifo_rdata;
  entry_tag_t            wr_tag, rd_tag;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  assign bar_k   = 3'(x_q >> BAR_SHIFT);
  assign bar_rgb = BAR_RGB[bar_k];

  // Field gi=2 is red (MSBs), gi=0 is blue (LSBs)
  for (genvar gi = 0; gi < 3; gi++) begin : g_bar
    assign bar_data[gi*FW +: FW] = {FW{bar_rgb[gi]}};
  end
  if (DATA_WIDTH > 3 * FW) begin : g_bar_pad
    assign bar_data[DATA_WIDTH-1:3*FW] = '0;
  end

  assign pix_data  = test_en_q ? bar_data : idata;
  assign pix_ok    = ifval & ilval;
  assign fv_rise   = ifval & ~ifval_q;
  assign fv_fall   = ~ifval & ifval_q;
  assign in_active = (state_q == ACTIVE);
  assign acc       = in_active & pix_ok;
  // The held pixel is the last of its line once the valid window closes
  assign line_end  = in_active & hold_valid_q & ilval_q & ~pix_ok;

  assign fifo_wr    = (acc & hold_valid_q) | line_end;
  assign wr_tag     = '{sof: hold_sof_q, eol: line_end};
  assign fifo_wdata = {wr_tag, hold_data_q};
  assign ovf_evt    = fifo_wr & fifo_full & ~(m_axis_tvalid & m_axis_tready);

  always_comb begin
    state_d      = state_q;
    ifval_d      = ifval;
    ilval_d      = ilval;
    test_en_d    = test_en_q;
    sof_pend_d   = sof_pend_q;
    x_d          = x_q;
    y_d          = y_q;
    last_len_d   = last_len_q;
    xcord_d      = xcord_q;
    ycord_d      = ycord_q;
    frame_w_d    = frame_w_q;
    frame_h_d    = frame_h_q;
    frame_cnt_d  = frame_cnt_q;
    eof_d        = 1'b0;
    ovf_d        = ovf_q & ~cfg_clr_ovf;
    hold_valid_d = hold_valid_q;
    hold_sof_d   = hold_sof_q;
    hold_data_d  = hold_data_q;

    case (state_q)
      WAIT_VB: begin
        if (!ifval) state_d = ARMED;
      end
      ARMED: begin
        if (fv_rise) begin
          state_d    = ACTIVE;
          test_en_d  = cfg_test_en;
          sof_pend_d = 1'b1;
          x_d        = '0;
          y_d        = '0;
        end
      end
      ACTIVE: begin
        if (acc) begin
          hold_valid_d = 1'b1;
          hold_sof_d   = sof_pend_q;
          hold_data_d  = pix_data;
          sof_pend_d   = 1'b0;
          x_d          = x_q + X_WIDTH'(1);
          xcord_d      = x_q;
          ycord_d      = y_q;
        end
        if (line_end) begin
          hold_valid_d = 1'b0;
          x_d          = '0;
          y_d          = y_q + Y_WIDTH'(1);
          last_len_d   = x_q;
        end
        if (ovf_evt) begin
          ovf_d        = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = DROP;
        end else if (fv_fall) begin
          eof_d       = 1'b1;
          frame_w_d   = line_end ? x_q : last_len_q;
          frame_h_d   = line_end ? y_q + Y_WIDTH'(1) : y_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ARMED;
        end
      end
      DROP: begin
        if (!ifval) state_d = ARMED;
      end
      default: state_d = WAIT_VB;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q      <= WAIT_VB;
      ifval_q      <= 1'b0;
      ilval_q      <= 1'b0;
      test_en_q    <= 1'b0;
      sof_pend_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      last_len_q   <= '0;
      xcord_q      <= '0;
      ycord_q      <= '0;
      frame_w_q    <= '0;
      frame_h_q    <= '0;
      frame_cnt_q  <= '0;
      eof_q        <= 1'b0;
      ovf_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_sof_q   <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ifval_q      <= ifval_d;
      ilval_q      <= ilval_d;
      test_en_q    <= test_en_d;
      sof_pend_q   <= sof_pend_d;
      x_q          <= x_d;
      y_q          <= y_d;
      last_len_q   <= last_len_d;
      xcord_q      <= xcord_d;
      ycord_q      <= ycord_d;
      frame_w_q    <= frame_w_d;
      frame_h_q    <= frame_h_d;
      frame_cnt_q  <= frame_cnt_d;
      eof_q        <= eof_d;
      ovf_q        <= ovf_d;
      hold_valid_q <= hold_valid_d;
      hold_sof_q   <= hold_sof_d;
      hold_data_q  <= hold_data_d;
    end
  end

  axis_sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .srst_n  (ARESETN),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  assign {rd_tag, m_axis_tdata} = fifo_rdata;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tuser  = rd_tag.sof;
  assign m_axis_tlast  = rd_tag.eol;
  assign xCord         = xcord_q;
  assign yCord         = ycord_q;
  assign frame_width   = frame_w_q;
  assign frame_height  = frame_h_q;
  assign frame_count   = frame_cnt_q;
  assign endOfFrame    = eof_q;
  assign ovf_flag      = ovf_q;

endmodule

// File: tb/tb_d5m_frame_axis_bridge.sv
// Directed bench for d5m_frame_axis_bridge: small FIFO and narrow bars so
// overflow and the full colour-bar sequence are reachable in short frames.
`timescale 1ns/1ps
module tb_d5m_frame_axis_bridge;
  import d5m_axis_pkg::*;

  localparam int DW = 24;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          ifval = 1'b0, ilval = 1'b0;
  logic          cfg_test_en = 1'b0, cfg_clr_ovf = 1'b0;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [11:0]   xCord, frame_width;
  logic [11:0]   yCord, frame_height;
  logic [15:0]   frame_count;
  logic          endOfFrame, ovf_flag;

  always #5 ACLK = ~ACLK;

  d5m_frame_axis_bridge #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (4), .X_WIDTH (12), .Y_WIDTH (12), .BAR_SHIFT (1)
  ) dut (
    .ACLK (ACLK), .ARESETN (ARESETN), .idata (idata), .ifval (ifval), .ilval (ilval),
    .cfg_test_en (cfg_test_en), .cfg_clr_ovf (cfg_clr_ovf), .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid), .m_axis_tdata (m_axis_tdata), .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast), .xCord (xCord), .yCord (yCord), .frame_width (frame_width),
    .frame_height (frame_height), .frame_count (frame_count), .endOfFrame (endOfFrame),
    .ovf_flag (ovf_flag)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat scoreboard and stall-stability monitor, sampled on the falling edge
  logic [DW-1:0] bq_data[$];
  logic          bq_user[$];
  logic          bq_last[$];
  int            eof_seen = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_user, prev_last;

  always @(negedge ACLK) begin
    if (ARESETN && m_axis_tvalid && m_axis_tready) begin
      bq_data.push_back(m_axis_tdata);
      bq_user.push_back(m_axis_tuser);
      bq_last.push_back(m_axis_tlast);
    end
    if (endOfFrame) eof_seen <= eof_seen + 1;
    if (ARESETN && stall_prev) begin
      check("stall_tvalid", m_axis_tvalid, 1);
      check("stall_tdata", m_axis_tdata, prev_data);
      check("stall_tuser", m_axis_tuser, prev_user);
      check("stall_tlast", m_axis_tlast, prev_last);
    end
    stall_prev <= ARESETN && m_axis_tvalid && !m_axis_tready;
    prev_data  <= m_axis_tdata;
    prev_user  <= m_axis_tuser;
    prev_last  <= m_axis_tlast;
  end

  // tready: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready
  int tr_mode = 0;
  int tr_ph = 0;
  initial forever begin
    @(posedge ACLK);
    #1;
    case (tr_mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = ((tr_ph % 4) == 0) || ((tr_ph % 4) == 3);
        tr_ph++;
      end
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic frame_start();
    ifval = 1'b1;
    tick(2);
  endtask

  task automatic frame_end();
    ifval = 1'b0;
    tick(3);
  endtask

  task automatic send_line(input int n, input logic [DW-1:0] base, input int flip_at);
    for (int i = 0; i < n; i++) begin
      if (i == flip_at) cfg_test_en = ~cfg_test_en;
      ilval = 1'b1;
      idata = base + DW'(i);
      tick(1);
    end
    ilval = 1'b0;
    idata = '0;
    tick(3);
  endtask

  task automatic wait_beats(input string tag, input int n);
    int k;
    k = 0;
    while (bq_data.size() < n && k < 300) begin
      tick(1);
      k++;
    end
    tick(3);
    check(tag, bq_data.size(), n);
  endtask

  task automatic pop_beat(input string tag, input logic [DW-1:0] d, input logic u, input logic l);
    logic [DW-1:0] gd;
    logic gu, gl;
    if (bq_data.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      gd = bq_data.pop_front();
      gu = bq_user.pop_front();
      gl = bq_last.pop_front();
      $display("beat %s: tdata=%06h tuser=%0d tlast=%0d", tag, gd, gu, gl);
      check({tag, "_tdata"}, gd, d);
      check({tag, "_tuser"}, gu, u);
      check({tag, "_tlast"}, gl, l);
    end
  endtask

  logic [DW-1:0] bars [8];
  int e0;

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Reset state
    tick(4);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_eof", endOfFrame, 0);
    ARESETN = 1'b1;
    tick(3);

    // 1: 2x4 frame, always ready
    e0 = eof_seen;
    frame_start();
    send_line(4, 24'd1, -1);
    send_line(4, 24'd5, -1);
    frame_end();
    wait_beats("t1_beats", 8);
    for (int i = 0; i < 8; i++)
      pop_beat("t1", DW'(i + 1), i == 0, (i == 3) || (i == 7));
    check("t1_width", frame_width, 4);
    check("t1_height", frame_height, 2);
    check("t1_count", frame_count, 1);
    check("t1_eof", eof_seen - e0, 1);

    // 2: same frame with toggling tready
    tr_ph = 0;
    tr_mode = 1;
    frame_start();
    send_line(4, 24'd1, -1);
    send_line(4, 24'd5, -1);
    frame_end();
    wait_beats("t2_beats", 8);
    tr_mode = 0;
    tick(2);
    for (int i = 0; i < 8; i++)
      pop_beat("t2", DW'(i + 1), i == 0, (i == 3) || (i == 7));
    check("t2_ovf", ovf_flag, 0);
    check("t2_count", frame_count, 2);

    // 3: overflow with tready low, then a clean frame
    tr_mode = 2;
    tick(2);
    e0 = eof_seen;
    frame_start();
    send_line(16, 24'h100, -1);
    check("t3_ovf", ovf_flag, 1);
    check("t3_state", 32'(dut.state_q), 32'(DROP));
    frame_end();
    check("t3_eof", eof_seen - e0, 0);
    check("t3_count_drop", frame_count, 2);
    tr_mode = 0;
    wait_beats("t3_stale", 4);
    for (int i = 0; i < 4; i++)
      pop_beat("t3_stale", 24'h100 + DW'(i), i == 0, 1'b0);
    frame_start();
    send_line(4, 24'h200, -1);
    frame_end();
    wait_beats("t3_good", 4);
    for (int i = 0; i < 4; i++)
      pop_beat("t3_good", 24'h200 + DW'(i), i == 0, i == 3);
    check("t3_count_good", frame_count, 3);
    check("t3_ovf_sticky", ovf_flag, 1);
    cfg_clr_ovf = 1'b1;
    tick(1);
    cfg_clr_ovf = 1'b0;
    tick(1);
    check("t3_ovf_clr", ovf_flag, 0);

    // 4: colour bars, enable flipped mid-line must not take effect
    cfg_test_en = 1'b1;
    tick(1);
    frame_start();
    send_line(16, 24'h300, 8);
    frame_end();
    wait_beats("t4_beats", 16);
    for (int i = 0; i < 16; i++)
      pop_beat("t4", bars[(i >> 1) & 7], i == 0, i == 15);
    check("t4_width", frame_width, 16);
    check("t4_height", frame_height, 1);
    check("t4_count", frame_count, 4);

    // 5: single-pixel first line (enable now low again)
    frame_start();
    send_line(1, 24'h55, -1);
    send_line(3, 24'h60, -1);
    frame_end();
    wait_beats("t5_beats", 4);
    pop_beat("t5_single", 24'h55, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      pop_beat("t5", 24'h60 + DW'(i), 1'b0, i == 2);
    check("t5_width", frame_width, 3);
    check("t5_height", frame_height, 2);
    check("t5_count", frame_count, 5);

    // 6: reset mid-line, released while ifval is high
    frame_start();
    ilval = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idata = 24'h70 + DW'(i);
      tick(1);
    end
    ARESETN = 1'b0;
    tick(3);
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    check("t6_rst_tuser", m_axis_tuser, 0);
    check("t6_rst_count", frame_count, 0);
    check("t6_rst_width", frame_width, 0);
    check("t6_rst_height", frame_height, 0);
    check("t6_rst_xcord", xCord, 0);
    check("t6_rst_ycord", yCord, 0);
    check("t6_rst_ovf", ovf_flag, 0);
    bq_data.delete();
    bq_user.delete();
    bq_last.delete();
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idata = 24'h78 + DW'(i);
      tick(1);
    end
    ilval = 1'b0;
    tick(3);
    check("t6_quiet_line", bq_data.size(), 0);
    frame_end();
    check("t6_quiet_frame", bq_data.size(), 0);
    check("t6_count_partial", frame_count, 0);
    frame_start();
    send_line(3, 24'h80, -1);
    frame_end();
    wait_beats("t6_beats", 3);
    for (int i = 0; i < 3; i++)
      pop_beat("t6", 24'h80 + DW'(i), i == 0, i == 2);
    check("t6_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
